// File: rtl/accumulator_unit_4_bit_pkg.sv
// Shared opcodes, FSM state encoding and the signed-overflow helper
// used by the 4-bit accumulator stage.
package accumulator_unit_4_bit_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Two's-complement overflow from sign bits of A, B and the raw result.
  // For SUB the effective B sign is inverted, hence the flipped compare.
  function automatic logic signed_ovf(input logic a3, input logic b3,
                                      input logic r3, input logic sub);
    if (sub) return (a3 != b3) && (r3 != a3);
    else     return (a3 == b3) && (r3 != a3);
  endfunction

endpackage

// File: rtl/adder_subtractor_4_bit.sv
// Combinational 4-bit adder/subtractor: M=0 gives num1+num2, M=1 gives
// num1+~num2+1. C4 is the raw carry-out of the 4-bit sum.
module adder_subtractor_4_bit (
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic       M,
  output logic [3:0] ans,
  output logic       C4
);

  logic [3:0] num2_eff;

  assign num2_eff  = num2 ^ {4{M}};
  assign {C4, ans} = {1'b0, num1} + {1'b0, num2_eff} + {4'b0000, M};

endmodule

// File: rtl/accumulator_unit_4_bit.sv
// Handshaked accumulator stage: latches one op in IDLE, computes it in EXEC
// through adder_subtractor_4_bit, and holds the result in DONE until taken.
//
// state  | meaning
// S_IDLE | in_ready=1, waiting for in_valid to latch op/operand
// S_EXEC | adder inputs stable, acc/flags written at the next edge
// S_DONE | out_valid=1, outputs frozen until out_ready
module accumulator_unit_4_bit
  import accumulator_unit_4_bit_pkg::*;
#(
  parameter bit SATURATE   = 1'b0,
  parameter bit OVF_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [3:0] operand,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] acc,
  output logic       carry,
  output logic       overflow,
  output logic       zero
);

  state_t     state;
  logic [1:0] op_q;
  logic [3:0] operand_q;

  logic [3:0] ans;
  logic       c4;
  logic       sub_sel;

  logic [3:0] acc_next;
  logic       carry_next;
  logic       ovf_next;
  logic       ovf_raw;

  assign sub_sel = (op_q == OP_SUB);

  adder_subtractor_4_bit u_addsub (
    .num1 (acc),
    .num2 (operand_q),
    .M    (sub_sel),
    .ans  (ans),
    .C4   (c4)
  );

  // Flags come from the unclamped sum; only acc itself is saturated.
  always_comb begin
    acc_next   = acc;
    carry_next = carry;
    ovf_next   = overflow;
    ovf_raw    = 1'b0;
    case (op_q)
      OP_LOAD: begin
        acc_next   = operand_q;
        carry_next = 1'b0;
        ovf_next   = OVF_STICKY ? overflow : 1'b0;
      end
      OP_ADD: begin
        ovf_raw    = signed_ovf(acc[3], operand_q[3], ans[3], 1'b0);
        carry_next = c4;
        acc_next   = (SATURATE && c4) ? 4'hF : ans;
        ovf_next   = OVF_STICKY ? (overflow | ovf_raw) : ovf_raw;
      end
      OP_SUB: begin
        ovf_raw    = signed_ovf(acc[3], operand_q[3], ans[3], 1'b1);
        carry_next = ~c4;
        acc_next   = (SATURATE && !c4) ? 4'h0 : ans;
        ovf_next   = OVF_STICKY ? (overflow | ovf_raw) : ovf_raw;
      end
      default: begin
        acc_next   = 4'h0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      operand_q <= 4'h0;
      acc       <= 4'h0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            operand_q <= operand;
            in_ready  <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc       <= acc_next;
          carry     <= carry_next;
          overflow  <= ovf_next;
          zero      <= (acc_next == 4'h0);
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
